// File: rtl/pc_pkg.sv
// pc_pkg: shared counter type, constants and saturating helpers for the fetch PC predictor
package pc_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  localparam int PC_STEP = 4;
  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;
  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction
  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction
endpackage

// File: rtl/bp_btb.sv
// bp_btb: direct-mapped branch target buffer with 2-bit direction counters, combinational lookup and synchronous training
module bp_btb import pc_pkg::*; #(
  parameter int WIDTH       = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc,
  output logic             hit,
  output logic             taken,
  output logic [WIDTH-1:0] target,
  input  logic             update_valid,
  input  logic [WIDTH-1:0] update_pc,
  input  logic             update_taken,
  input  logic [WIDTH-1:0] update_target
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WIDTH - IDX_W - 2;
  logic [BTB_ENTRIES-1:0] valid;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [WIDTH-1:0]       target_q [BTB_ENTRIES];
  ctr_t                   ctr_q    [BTB_ENTRIES];
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       uidx;
  logic                   uhit;
  logic                   unused_lsbs;
  assign idx         = pc[IDX_W+1:2];
  assign uidx        = update_pc[IDX_W+1:2];
  assign hit         = valid[idx] && (tag_q[idx] == pc[WIDTH-1:IDX_W+2]);
  assign taken       = hit && ctr_q[idx][1];
  assign target      = hit ? target_q[idx] : '0;
  assign uhit        = valid[uidx] && (tag_q[uidx] == update_pc[WIDTH-1:IDX_W+2]);
  assign unused_lsbs = ^{pc[1:0], update_pc[1:0]};
  // A not-taken miss never allocates, so cold entries only hold taken history
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else if (update_valid) begin
      if (uhit) begin
        ctr_q[uidx] <= update_taken ? ctr_inc(ctr_q[uidx]) : ctr_dec(ctr_q[uidx]);
        if (update_taken) target_q[uidx] <= update_target;
      end else if (update_taken) begin
        valid[uidx]    <= 1'b1;
        tag_q[uidx]    <= update_pc[WIDTH-1:IDX_W+2];
        target_q[uidx] <= update_target;
        ctr_q[uidx]    <= CTR_ALLOC;
      end
    end
endmodule

// File: rtl/fetch_pc_predictor.sv
// fetch_pc_predictor: fetch PC register steered by BTB predictions and execute-stage redirects
module fetch_pc_predictor import pc_pkg::*; #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               BTB_ENTRIES  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             update_valid,
  input  logic [WIDTH-1:0] update_pc,
  input  logic             update_taken,
  input  logic [WIDTH-1:0] update_target,
  output logic [WIDTH-1:0] PC,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target
);
  logic [WIDTH-1:0] next_pc;
  logic             hit_unused;
  bp_btb #(.WIDTH(WIDTH), .BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk(clk),
    .rst_n(rst_n),
    .pc(PC),
    .hit(hit_unused),
    .taken(pred_taken),
    .target(pred_target),
    .update_valid(update_valid),
    .update_pc(update_pc),
    .update_taken(update_taken),
    .update_target(update_target)
  );
  // Redirect outranks stall so a flush is never lost behind a hazard hold
  always_comb next_pc = redirect_valid ? redirect_target :
                        stall          ? PC :
                        pred_taken     ? pred_target : PC + WIDTH'(PC_STEP);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) PC <= RESET_VECTOR;
    else        PC <= next_pc;
endmodule

// File: tb/tb_fetch_pc_predictor.sv
// tb_fetch_pc_predictor: directed test of the fetch PC predictor against an abstract per-cycle model
module tb_fetch_pc_predictor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, redirect_valid, update_valid, update_taken;
  logic [31:0] redirect_target, update_pc, update_target;
  logic [31:0] PC, pred_target;
  logic        pred_taken;
  int checks = 0;
  int fails = 0;

  fetch_pc_predictor #(.WIDTH(32), .RESET_VECTOR(32'h100), .BTB_ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .PC(PC), .pred_taken(pred_taken), .pred_target(pred_target)
  );

  always #5 clk = ~clk;

  // model: table keyed by word index, tag kept as the whole upper address
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_pc;

  function automatic void model_pred(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int i;
    bit h;
    i  = int'((pc / 4) % 16);
    h  = m_valid[i] && (m_tag[i] == pc / 64);
    t  = h && (m_ctr[i] >= 2);
    tg = h ? m_tgt[i] : 32'h0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h100;
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
    end else begin
      bit          t;
      logic [31:0] tg;
      int          i;
      model_pred(m_pc, t, tg);
      if (redirect_valid) m_pc = redirect_target;
      else if (stall)     m_pc = m_pc;
      else if (t)         m_pc = tg;
      else                m_pc = m_pc + 32'd4;
      if (update_valid) begin
        i = int'((update_pc / 4) % 16);
        if (m_valid[i] && m_tag[i] == update_pc / 64) begin
          if (update_taken) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = update_target;
          end else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end else if (update_taken) begin
          m_valid[i] = 1; m_tag[i] = update_pc / 64; m_tgt[i] = update_target; m_ctr[i] = 2;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit          t;
    logic [31:0] tg;
    model_pred(m_pc, t, tg);
    chk("model_pc", PC, m_pc);
    chk("model_pred_taken", {31'b0, pred_taken}, {31'b0, t});
    chk("model_pred_target", pred_target, tg);
  end

  task automatic cyc(input logic rv, input logic [31:0] rt, input logic st,
                     input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg);
    redirect_valid = rv; redirect_target = rt; stall = st;
    update_valid = uv; update_pc = upc; update_taken = ut; update_target = utg;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    redirect_valid = 0; redirect_target = 0; stall = 0;
    update_valid = 0; update_pc = 0; update_taken = 0; update_target = 0;
    repeat (2) @(negedge clk);
    chk("reset_pc", PC, 32'h100);
    chk("reset_pred", {31'b0, pred_taken}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk); chk("fall_104", PC, 32'h104);
    @(negedge clk); chk("fall_108", PC, 32'h108);
    chk("fall_pred", {31'b0, pred_taken}, 32'h0);
    cyc(0, 0, 0, 1, 32'h20, 1, 32'h80);
    cyc(1, 32'h20, 0, 0, 0, 0, 0);
    chk("alloc_pc", PC, 32'h20);
    chk("alloc_pred", {31'b0, pred_taken}, 32'h1);
    chk("alloc_target", pred_target, 32'h80);
    idle();
    chk("pred_follow", PC, 32'h80);
    cyc(0, 0, 0, 1, 32'h20, 1, 32'h80);
    cyc(0, 0, 0, 1, 32'h20, 1, 32'h80);
    cyc(0, 0, 0, 1, 32'h20, 0, 0);
    cyc(1, 32'h20, 0, 0, 0, 0, 0);
    chk("hyst_still_taken", {31'b0, pred_taken}, 32'h1);
    cyc(0, 0, 1, 1, 32'h20, 0, 0);
    chk("stall_hold_hit", PC, 32'h20);
    chk("weak_nt_pred", {31'b0, pred_taken}, 32'h0);
    idle();
    chk("weak_nt_fall", PC, 32'h24);
    cyc(1, 32'h40, 1, 0, 0, 0, 0);
    chk("redirect_over_stall", PC, 32'h40);
    cyc(0, 0, 0, 1, 32'h20, 1, 32'h80);
    cyc(0, 0, 0, 1, 32'h60, 1, 32'h200);
    cyc(1, 32'h20, 0, 0, 0, 0, 0);
    chk("alias_evicted", {31'b0, pred_taken}, 32'h0);
    cyc(1, 32'h60, 0, 0, 0, 0, 0);
    chk("alias_new_pred", {31'b0, pred_taken}, 32'h1);
    chk("alias_new_target", pred_target, 32'h200);
    idle();
    chk("alias_follow", PC, 32'h200);
    cyc(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0);
    chk("wrap_top", PC, 32'hFFFFFFFC);
    idle();
    chk("wrap_zero", PC, 32'h0);
    cyc(1, 32'h104, 0, 0, 0, 0, 0);
    chk("pre_reset_pc", PC, 32'h104);
    redirect_valid = 1; redirect_target = 32'h400;
    update_valid = 1; update_pc = 32'h100; update_taken = 1; update_target = 32'h300;
    #2 rst_n = 1'b0;
    #1 chk("async_reset_pc", PC, 32'h100);
    chk("async_reset_pred", {31'b0, pred_taken}, 32'h0);
    @(negedge clk);
    chk("reset_discard_redirect", PC, 32'h100);
    redirect_valid = 0; update_valid = 0;
    rst_n = 1'b1;
    cyc(1, 32'h20, 0, 0, 0, 0, 0);
    chk("post_reset_miss_20", {31'b0, pred_taken}, 32'h0);
    cyc(1, 32'h60, 0, 0, 0, 0, 0);
    chk("post_reset_miss_60", {31'b0, pred_taken}, 32'h0);
    cyc(1, 32'h100, 0, 0, 0, 0, 0);
    chk("post_reset_miss_100", {31'b0, pred_taken}, 32'h0);
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/fetch_pc_predictor.md
# fetch_pc_predictor

Parametrised fetch-stage PC generator with an integrated direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. Each cycle it presents the fetch PC, looks the PC up in the BTB and speculatively steers the next PC to the predicted target. Execute-stage redirects (mispredictions, JALR) override the prediction, and execute-stage training updates the table. It replaces the fixed-width, non-predicting PC register in the fetch stage of the pipelined core.

## Interface
- `WIDTH`, 32, PC/target width in bits.
- `RESET_VECTOR`, 0, PC value loaded on reset.
- `BTB_ENTRIES`, 16, number of BTB entries; power of two, at least 2.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `stall`  in  1  hold the fetch PC; from the hazard unit.
- `redirect_valid`  in  1  execute-stage correction; next PC is `redirect_target`.
- `redirect_target`  in  WIDTH  corrected PC (branch/JAL target, JALR result, or fall-through).
- `update_valid`  in  1  train the BTB with a resolved control-flow instruction.
- `update_pc`  in  WIDTH  PC of the resolved instruction (PCE).
- `update_taken`  in  1  resolved direction.
- `update_target`  in  WIDTH  resolved taken target.
- `PC`  out  WIDTH  current fetch PC.
- `pred_taken`  out  1  prediction for `PC`; pipelined forward for the execute-stage compare.
- `pred_target`  out  WIDTH  predicted target for `PC`; valid when `pred_taken` is 1.

## Operation
- Index bits are `IDX_W = $clog2(BTB_ENTRIES)`.
- Index = `PC[IDX_W+1:2]`. Tag = `PC[WIDTH-1:IDX_W+2]`. PC bits [1:0] are ignored for lookup.
- Entry fields: `valid`, `tag`, `target` (WIDTH bits) and `ctr` (2 bits: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- Lookup is combinational from registered `PC`.
  - `hit` = entry valid and tag equal.
  - `pred_taken` = `hit & ctr[1]`.
  - `pred_target` = entry target when hit, else 0.
- Next-PC priority, highest first:
  1. `redirect_valid`: next PC = `redirect_target`. This overrides `stall`.
  2. `stall`: PC holds.
  3. `pred_taken`: next PC = `pred_target`.
  4. Otherwise next PC = `PC + 4`, wrapping modulo 2^WIDTH.
- Training happens on `update_valid`, independent of `stall` and `redirect_valid`.
  - Tag hit, taken: `ctr` saturating increment; `target` ← `update_target`.
  - Tag hit, not taken: `ctr` saturating decrement; `target` unchanged.
  - Miss, taken: allocate (overwrite) the entry with `valid`=1, new tag, target, `ctr`=10.
  - Miss, not taken: no write.
- Same-cycle lookup and update of the same entry: the lookup sees the old contents. The write is visible from the next cycle.
- Targets and redirects are used unmodified. No alignment forcing is applied.

## Timing
- Reset (`rst_n` low, asynchronous) takes effect immediately, independent of `clk`:
  - `PC` = `RESET_VECTOR`.
  - All entries: `valid`=0, `ctr`=01, `tag`=0, `target`=0.
  - `pred_taken`=0 and `pred_target`=0 as a consequence.
- Deassertion is synchronised externally. The first edge after release applies normal next-PC rules to `RESET_VECTOR`.
- A redirect or prediction takes effect at the next edge, so latency is 1 cycle. Predictions therefore give zero-bubble taken branches. A misprediction costs the execute-stage redirect latency.
- Updates are written at the rising edge on which `update_valid` is sampled.
- Reset asserted mid-update or mid-redirect discards both. No partial entry write survives.

## Structure
- Package `pc_pkg` holds:
  - `ctr_t` enum `{SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11}`.
  - `PC_STEP = 4`.
  - `CTR_RESET = WNT`, `CTR_ALLOC = WT`.
  - Saturating `ctr_inc` and `ctr_dec` functions.
- Sub-module `bp_btb` (parameters `WIDTH`, `BTB_ENTRIES`) owns:
  - the entry arrays;
  - the combinational lookup port (pc → hit, taken, target);
  - the synchronous update port.
- `fetch_pc_predictor` owns the PC register and the next-PC mux.

## Test plan
- Reset and fall-through: `RESET_VECTOR`=0x100, release reset with no updates → `PC` sequence 0x100, 0x104, 0x108, with `pred_taken`=0 throughout.
- Allocate and predict: update {pc=0x20, taken=1, target=0x80}, then redirect to 0x20 → after the redirect edge `pred_taken`=1 and `pred_target`=0x80. The next `PC` is 0x80.
- Counter saturation and hysteresis:
  - Train 0x20 taken ×3 → ctr=11.
  - Then one not-taken → ctr=10, still predicts taken.
  - A second not-taken → ctr=01, `PC` 0x20 falls through to 0x24.
- Priority:
  - `stall`=1 with `redirect_valid`=1, target 0x40 → `PC`=0x40 next cycle.
  - `stall`=1 alone at 0x20 with a hit → `PC` stays 0x20.
- Aliasing and wrap:
  - Update pc=0x20 taken, then pc=0x60 taken (same index, BTB_ENTRIES=16) → 0x20 no longer hits.
  - With WIDTH=32, `PC`=0xFFFFFFFC and no hit → next `PC`=0x0.
- Async reset mid-run: drop `rst_n` between clock edges at `PC`=0x104 → `PC`=`RESET_VECTOR` immediately. All prior BTB entries miss after release.
